// File: rtl/act_skew_feeder.sv
// act_skew_feeder: skews activation vectors onto a systolic array left edge.
// Row r is delayed by r+1 registers; a zero drain flushes the array.
module act_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] s_data,
    input  logic                       s_last,
    output logic [ROWS*DATA_WIDTH-1:0] act_out,
    output logic                       en_compute,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                vec_count
);

    localparam int DW   = DATA_WIDTH;
    localparam int DLEN = ROWS + COLS - 1;
    localparam int CW   = $clog2(DLEN + 1);
    localparam logic [CW-1:0] DRAIN_LEN = CW'(DLEN);
    localparam logic [CW-1:0] DRAIN_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t                 r_state;
    logic                   r_en;
    logic                   r_done;
    logic [15:0]            r_vcnt;
    logic [CW-1:0]          r_dcnt;

    logic                   w_accept;
    logic                   w_advance;
    logic                   w_clear;
    logic [ROWS*DW-1:0]     w_inj;

    assign s_ready    = (r_state == STREAM);
    assign busy       = (r_state != IDLE);
    assign en_compute = r_en;
    assign done       = r_done;
    assign vec_count  = r_vcnt;

    assign w_accept  = s_valid && s_ready;
    assign w_advance = w_accept || (r_state == DRAIN);
    assign w_clear   = (r_state == IDLE) && start;
    assign w_inj     = (r_state == DRAIN) ? '0 : s_data;

    // Control FSM: stream/drain sequencing with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_vcnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_en   <= w_advance;
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= STREAM;
                        r_vcnt  <= '0;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (r_vcnt != 16'hFFFF) begin
                            r_vcnt <= r_vcnt + 16'd1;
                        end
                        if (s_last) begin
                            r_state <= DRAIN;
                            r_dcnt  <= DRAIN_LEN;
                        end
                    end
                end
                DRAIN: begin
                    r_dcnt <= r_dcnt - DRAIN_ONE;
                    if (r_dcnt == DRAIN_ONE) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [(r+1)*DW-1:0] r_pipe;

        if (r == 0) begin : g_first
            // Row 0: single register, loads the injected element on advance
            always_ff @(posedge clk) begin
                if (rst || w_clear) begin
                    r_pipe <= '0;
                end else if (w_advance) begin
                    r_pipe <= w_inj[0 +: DW];
                end
            end
        end else begin : g_rest
            // Row r: r+1 stage shift chain, newest at the bottom slot
            always_ff @(posedge clk) begin
                if (rst || w_clear) begin
                    r_pipe <= '0;
                end else if (w_advance) begin
                    r_pipe <= {r_pipe[r*DW-1:0], w_inj[r*DW +: DW]};
                end
            end
        end

        assign act_out[r*DW +: DW] = r_pipe[r*DW +: DW];
    end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: activation element width in bits, signed two's complement.
REQ-002 SHALL have parameter ROWS, default 4: number of array rows fed, one element per row.
REQ-003 SHALL have parameter COLS, default 4: number of array columns, used only for drain length.
REQ-004 SHALL have port clk  input  1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1: one-cycle request to begin a stream.
REQ-007 SHALL have port s_valid  input  1: the input vector is valid.
REQ-008 SHALL have port s_ready  output  1: the feeder accepts a vector this cycle.
REQ-009 SHALL have port s_data  input  ROWS*DATA_WIDTH: activation vector; row r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port s_last  input  1: marks the final vector of the stream.
REQ-011 SHALL have port act_out  output  ROWS*DATA_WIDTH: skewed activations to the array left edge, same packing as s_data.
REQ-012 SHALL have port en_compute  output  1: array-wide MAC and shift enable.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.
REQ-014 SHALL have port done  output  1: one-cycle pulse at end of drain.
REQ-015 SHALL have port vec_count  output  16: number of vectors accepted in the current or most recent stream.

Function
REQ-016 SHALL implement the states IDLE, STREAM and DRAIN.
REQ-017 IDLE->STREAM SHALL occur when start=1; start SHALL be ignored in STREAM and DRAIN.
REQ-018 On entry to STREAM, vec_count SHALL be cleared to 0.
REQ-019 s_ready SHALL be 1 exactly when state=STREAM, driven combinationally from state only.
REQ-020 An accept SHALL be a cycle with s_valid=1 and s_ready=1; each accept increments vec_count, which saturates at 0xFFFF.
REQ-021 An accept with s_last=1 SHALL move STREAM->DRAIN and load the drain counter with ROWS+COLS-1.
REQ-022 An advance SHALL be either an accept or any cycle in DRAIN.
REQ-023 The skew pipeline SHALL shift only on an advance; in STREAM with s_valid=0 nothing shifts and the outputs hold.
REQ-024 Skew: after advance k, act_out row r SHALL equal the row-r element injected at advance k-r; the value is 0 if that advance did not occur in the current stream.
REQ-025 Row 0 SHALL have a one-register delay; row r SHALL have r+1 registers.
REQ-026 During DRAIN, the injected vector SHALL be all zeros.
REQ-027 en_compute SHALL be registered: 1 in the cycle after an advance, otherwise 0, so that it is always coincident with the updated act_out.
REQ-028 Each DRAIN cycle SHALL decrement the drain counter; the cycle in which it reaches 0 SHALL move DRAIN->IDLE and register done=1 for exactly the following cycle.
REQ-029 The skew registers SHALL be cleared on IDLE->STREAM, so that no data from a previous stream leaks into the next one.
REQ-030 A single-vector stream (first accept carries s_last) SHALL be legal and SHALL drain identically.
REQ-031 s_data SHALL be ignored when no accept occurs.

Reset
REQ-032 rst=1 SHALL force, at the next clk edge: state=IDLE, act_out=0, all skew registers=0, en_compute=0, done=0, vec_count=0, drain counter=0.
REQ-033 rst SHALL take priority over every other input, including mid-STREAM and mid-DRAIN; no done pulse SHALL follow an aborted stream.

Verification
REQ-034 Scenario: ROWS=4, COLS=4; start; 3 back-to-back vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, the last carrying s_last -> act_out sequence is row0: 1,5,9,0..., row1: 0,2,6,10,..., row3: 0,0,0,4,8,12; en_compute is high for 3+7 cycles; done pulses once; vec_count=3.
REQ-035 Scenario: the same stream with s_valid=0 for 2 cycles between vectors -> act_out holds and en_compute=0 during the gaps; the skewed value sequence is identical to REQ-034.
REQ-036 Scenario: a single vector {7,-1,-128,127} with s_last -> row r shows its element at advance r (0-based), sign preserved; done arrives 7 cycles after the accept.
REQ-037 Scenario: rst pulsed during DRAIN -> the next cycle shows all outputs 0 and IDLE; no done pulse follows.
REQ-038 Scenario: start asserted during STREAM and DRAIN -> no effect; then a second stream after done -> its first outputs show no residue from the first stream.
REQ-039 Scenario: s_valid=1 while IDLE -> s_ready=0, no accept, vec_count unchanged, en_compute=0.
